// File: rtl/loteria_pkg.sv
// Shared types and constants for the multi-player lottery checker.
package loteria_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PLAY   = 3'd2,
    EVAL   = 3'd3,
    RESULT = 3'd4,
    FIM    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PREMIO_NADA  = 2'd0,
    PREMIO_DOIS  = 2'd1,
    PREMIO_SEQ   = 2'd2,
    PREMIO_TOTAL = 2'd3
  } premio_e;

  localparam int RUN_MIN = 3;

  // Score points awarded for each prize code.
  function automatic logic [2:0] premio_pontos(input premio_e p);
    logic [2:0] pts;
    case (p)
      PREMIO_DOIS:  pts = 3'd1;
      PREMIO_SEQ:   pts = 3'd2;
      PREMIO_TOTAL: pts = 3'd4;
      default:      pts = 3'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/loteria_placar.sv
// Per-player saturating score registers and the combinational winner search.
module loteria_placar
  import loteria_pkg::*;
#(
  parameter int  PLAYERS = 2,
  parameter int  SCORE_W = 5,
  localparam int PW      = $clog2(PLAYERS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       add_en_i,
  input  logic [PW-1:0]              add_idx_i,
  input  logic [2:0]                 pontos_i,
  output logic [PLAYERS*SCORE_W-1:0] placar_o,
  output logic [PW-1:0]              vencedor_o
);

  localparam int SW1 = SCORE_W + 1;

  logic [SCORE_W-1:0] score_q [PLAYERS];
  logic [SCORE_W-1:0] score_d [PLAYERS];
  logic [SCORE_W:0]   sum_s;
  logic [SCORE_W-1:0] best_val_s;

  // Next score values: clear, saturating add for one player, or hold.
  always_comb begin
    for (int i = 0; i < PLAYERS; i++) score_d[i] = score_q[i];
    sum_s = {1'b0, score_q[add_idx_i]} + SW1'(pontos_i);
    if (clr_i) begin
      for (int i = 0; i < PLAYERS; i++) score_d[i] = '0;
    end else if (add_en_i) begin
      score_d[add_idx_i] = sum_s[SCORE_W] ? '1 : sum_s[SCORE_W-1:0];
    end else begin
      for (int i = 0; i < PLAYERS; i++) score_d[i] = score_q[i];
    end
  end

  // Score registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PLAYERS; i++) score_q[i] <= '0;
    end else begin
      for (int i = 0; i < PLAYERS; i++) score_q[i] <= score_d[i];
    end
  end

  // Packing plus argmax; strict > keeps the lowest index on ties.
  always_comb begin
    placar_o   = '0;
    vencedor_o = '0;
    best_val_s = score_q[0];
    for (int i = 0; i < PLAYERS; i++) placar_o[i*SCORE_W +: SCORE_W] = score_q[i];
    for (int i = 1; i < PLAYERS; i++) begin
      if (score_q[i] > best_val_s) begin
        best_val_s = score_q[i];
        vencedor_o = PW'(i);
      end else begin
        best_val_s = best_val_s;
      end
    end
  end

endmodule

// File: rtl/loteria_multi.sv
// Multi-player lottery checker: loads a draw, scores one ticket per player
// in turn and reports the winner when the game ends.
module loteria_multi
  import loteria_pkg::*;
#(
  parameter int  NUM_W   = 4,
  parameter int  SEQ_LEN = 4,
  parameter int  PLAYERS = 2,
  parameter int  SCORE_W = 5,
  localparam int CNT_W   = $clog2(SEQ_LEN + 1),
  localparam int PW      = $clog2(PLAYERS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_W-1:0]           numero,
  input  logic                       insere,
  input  logic                       carrega,
  input  logic                       novo_jogo,
  input  logic                       fim_jogo,
  output logic [1:0]                 premio,
  output logic                       premio_valido,
  output logic [CNT_W-1:0]           acertos,
  output logic [PW-1:0]              jogador,
  output logic [PLAYERS*SCORE_W-1:0] placar,
  output logic [PW-1:0]              vencedor,
  output logic                       fim
);

  localparam int IDX_W = $clog2(SEQ_LEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0] draw_q [SEQ_LEN];
  logic [NUM_W-1:0] draw_d [SEQ_LEN];
  logic [CNT_W-1:0] hits_q, hits_d, run_q, run_d, maxrun_q, maxrun_d;
  logic [CNT_W-1:0] acertos_q, acertos_d;
  logic [PW-1:0]    jog_q, jog_d, venc_q, venc_d;
  premio_e          premio_q, premio_d, premio_calc_s;
  logic             valido_q, valido_d, fim_q, fim_d;
  logic             match_s, last_s, placar_clr_s, placar_add_s;
  logic [PW-1:0]    best_s;

  // Prize code of the ticket just completed, first matching rule wins.
  always_comb begin
    if (hits_q == CNT_W'(SEQ_LEN)) begin
      premio_calc_s = PREMIO_TOTAL;
    end else if (maxrun_q >= CNT_W'(RUN_MIN)) begin
      premio_calc_s = PREMIO_SEQ;
    end else if (hits_q >= CNT_W'(2)) begin
      premio_calc_s = PREMIO_DOIS;
    end else begin
      premio_calc_s = PREMIO_NADA;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    draw_d       = draw_q;
    hits_d       = hits_q;
    run_d        = run_q;
    maxrun_d     = maxrun_q;
    jog_d        = jog_q;
    premio_d     = premio_q;
    acertos_d    = acertos_q;
    valido_d     = 1'b0;
    placar_clr_s = 1'b0;
    placar_add_s = 1'b0;
    match_s      = (numero == draw_q[idx_q]);
    last_s       = (idx_q == IDX_W'(SEQ_LEN - 1));
    case (state_q)
      IDLE: begin
        if (fim_jogo) begin
          state_d = FIM;
        end else if (carrega) begin
          state_d = LOAD;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (fim_jogo) begin
          state_d = IDLE;
          idx_d   = '0;
          for (int i = 0; i < SEQ_LEN; i++) draw_d[i] = '0;
        end else if (insere) begin
          draw_d[idx_q] = numero;
          if (last_s) begin
            state_d  = PLAY;
            idx_d    = '0;
            jog_d    = '0;
            hits_d   = '0;
            run_d    = '0;
            maxrun_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      PLAY: begin
        if (fim_jogo) begin
          state_d  = FIM;
          idx_d    = '0;
          hits_d   = '0;
          run_d    = '0;
          maxrun_d = '0;
        end else if (insere) begin
          hits_d   = hits_q + CNT_W'(match_s);
          run_d    = match_s ? run_q + 1'b1 : '0;
          maxrun_d = (run_d > maxrun_q) ? run_d : maxrun_q;
          if (last_s) begin
            state_d = EVAL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = PLAY;
        end
      end
      EVAL: begin
        state_d      = RESULT;
        premio_d     = premio_calc_s;
        acertos_d    = hits_q;
        placar_add_s = 1'b1;
        valido_d     = 1'b1;
      end
      RESULT: begin
        if (fim_jogo) begin
          state_d = FIM;
        end else if (novo_jogo) begin
          state_d  = PLAY;
          jog_d    = (jog_q == PW'(PLAYERS - 1)) ? '0 : jog_q + 1'b1;
          idx_d    = '0;
          hits_d   = '0;
          run_d    = '0;
          maxrun_d = '0;
        end else begin
          state_d = RESULT;
        end
      end
      FIM: begin
        if (fim_jogo) begin
          state_d = FIM;
        end else if (novo_jogo) begin
          state_d      = PLAY;
          placar_clr_s = 1'b1;
          jog_d        = '0;
          idx_d        = '0;
          hits_d       = '0;
          run_d        = '0;
          maxrun_d     = '0;
        end else if (carrega) begin
          state_d      = LOAD;
          placar_clr_s = 1'b1;
          jog_d        = '0;
          idx_d        = '0;
        end else begin
          state_d = FIM;
        end
      end
      default: state_d = IDLE;
    endcase
    fim_d = (state_d == FIM);
    // The winner is captured once, on the edge that enters FIM.
    if ((state_d == FIM) && (state_q != FIM)) begin
      venc_d = best_s;
    end else begin
      venc_d = venc_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      for (int i = 0; i < SEQ_LEN; i++) draw_q[i] <= '0;
      hits_q    <= '0;
      run_q     <= '0;
      maxrun_q  <= '0;
      jog_q     <= '0;
      premio_q  <= PREMIO_NADA;
      acertos_q <= '0;
      valido_q  <= 1'b0;
      fim_q     <= 1'b0;
      venc_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      for (int i = 0; i < SEQ_LEN; i++) draw_q[i] <= draw_d[i];
      hits_q    <= hits_d;
      run_q     <= run_d;
      maxrun_q  <= maxrun_d;
      jog_q     <= jog_d;
      premio_q  <= premio_d;
      acertos_q <= acertos_d;
      valido_q  <= valido_d;
      fim_q     <= fim_d;
      venc_q    <= venc_d;
    end
  end

  loteria_placar #(
    .PLAYERS (PLAYERS),
    .SCORE_W (SCORE_W)
  ) u_placar (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (placar_clr_s),
    .add_en_i   (placar_add_s),
    .add_idx_i  (jog_q),
    .pontos_i   (premio_pontos(premio_calc_s)),
    .placar_o   (placar),
    .vencedor_o (best_s)
  );

  assign premio        = premio_q;
  assign premio_valido = valido_q;
  assign acertos       = acertos_q;
  assign jogador       = jog_q;
  assign vencedor      = venc_q;
  assign fim           = fim_q;

endmodule

// File: tb/tb_loteria_multi.sv
// Scoreboard bench for loteria_multi: a reference model predicts each ticket
// result and a monitor compares it when premio_valido pulses.
module tb_loteria_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] numero = 4'd0;
  logic       insere = 1'b0, carrega = 1'b0, novo_jogo = 1'b0, fim_jogo = 1'b0;
  logic [1:0] premio;
  logic       premio_valido;
  logic [2:0] acertos;
  logic [0:0] jogador;
  logic [9:0] placar;
  logic [0:0] vencedor;
  logic       fim;

  loteria_multi #(.NUM_W(4), .SEQ_LEN(4), .PLAYERS(2), .SCORE_W(5)) dut (
    .clock(clock), .reset(reset), .numero(numero), .insere(insere),
    .carrega(carrega), .novo_jogo(novo_jogo), .fim_jogo(fim_jogo),
    .premio(premio), .premio_valido(premio_valido), .acertos(acertos),
    .jogador(jogador), .placar(placar), .vencedor(vencedor), .fim(fim)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] pr;
    logic [2:0] ac;
    logic [9:0] pl;
    int         at;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_pass = 0, n_push = 0, n_pop = 0, cyc_n = 0;
  int   draw_m[4];
  int   score_m[2];
  int   jog_m = 0;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [9:0] pack_scores();
    logic [4:0] s0, s1;
    s0 = score_m[0][4:0];
    s1 = score_m[1][4:0];
    return {s1, s0};
  endfunction

  // Monitor: every premio_valido pulse must match the oldest pending ticket.
  always @(negedge clock) begin
    if (premio_valido === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got premio_valido=1 expected 0 with no ticket pending");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_pop++;
        check("premio", premio, e.pr);
        check("acertos", acertos, e.ac);
        check("placar", placar, e.pl);
        check("latency_cycle", cyc_n, e.at);
      end
    end
  end

  task automatic cyc(input bit ins, input int num, input bit car, input bit nov, input bit fj);
    insere = ins; numero = num[3:0]; carrega = car; novo_jogo = nov; fim_jogo = fj;
    @(posedge clock); #1;
    insere = 1'b0; carrega = 1'b0; novo_jogo = 1'b0; fim_jogo = 1'b0;
  endtask

  task automatic load_draw(input int d[4]);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, d[i], 1'b0, 1'b0, 1'b0);
    draw_m = d;
    jog_m  = 0;
    check("jogador_after_load", jogador, jog_m);
  endtask

  // Reference: count positional hits and the longest run of consecutive hits.
  task automatic play_ticket(input int t[4]);
    int   hits, run, best, pr, pts;
    exp_t e;
    hits = 0; run = 0; best = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, t[i], 1'b0, 1'b0, 1'b0);
      if (t[i] == draw_m[i]) begin hits++; run++; end
      else run = 0;
      if (run > best) best = run;
    end
    pr  = (hits == 4) ? 3 : (best >= 3) ? 2 : (hits >= 2) ? 1 : 0;
    pts = (pr == 3) ? 4 : pr;
    score_m[jog_m] = (score_m[jog_m] + pts > 31) ? 31 : score_m[jog_m] + pts;
    e.pr = pr[1:0]; e.ac = hits[2:0]; e.pl = pack_scores(); e.at = cyc_n + 1;
    sb_q.push_back(e);
    n_push++;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_player();
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    jog_m = (jog_m + 1) % 2;
    check("jogador_next", jogador, jog_m);
  endtask

  task automatic rand_ticket();
    int t[4];
    for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 1) == 1) ? draw_m[i] : int'($urandom_range(0, 15));
    play_ticket(t);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_premio"}, premio, 0);
    check({tag, "_valido"}, premio_valido, 0);
    check({tag, "_acertos"}, acertos, 0);
    check({tag, "_jogador"}, jogador, 0);
    check({tag, "_placar"}, placar, 0);
    check({tag, "_vencedor"}, vencedor, 0);
    check({tag, "_fim"}, fim, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t[4];
    int d[4];
    int perf;
    score_m = '{0, 0};
    reset = 1'b0;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    check_all_zero("reset");

    d = '{3, 5, 8, 1};
    load_draw(d);
    t = '{3, 5, 8, 1}; play_ticket(t);
    next_player();
    t = '{3, 5, 8, 0}; play_ticket(t);
    next_player();
    t = '{3, 0, 8, 0}; play_ticket(t);
    next_player();
    t = '{0, 0, 0, 0}; play_ticket(t);
    next_player();

    // Abort mid-ticket: no points, winner 0 with 5/2.
    cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("abort_fim", fim, 1);
    check("abort_vencedor", vencedor, 0);
    check("abort_placar", placar, pack_scores());
    check("abort_premio_held", premio, 0);
    check("abort_valido", premio_valido, 0);

    // Restart with same draw, then a 2/2 tie.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    score_m = '{0, 0}; jog_m = 0;
    check("restart_placar", placar, 0);
    check("restart_fim", fim, 0);
    check("restart_jogador", jogador, 0);
    t = '{3, 5, 8, 0}; play_ticket(t);
    next_player();
    t = '{3, 5, 8, 0}; play_ticket(t);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("tie_fim", fim, 1);
    check("tie_vencedor", vencedor, 0);

    // Abandoned load, then a random draw and random tickets.
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    score_m = '{0, 0};
    check("load_clears_placar", placar, 0);
    cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("load_abort_fim", fim, 0);
    for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 15));
    load_draw(d);
    for (int k = 0; k < 12; k++) begin
      rand_ticket();
      next_player();
    end

    // Saturation: player 0 keeps scoring perfect tickets.
    perf = 0;
    while (perf < 9) begin
      if (jog_m == 0) begin play_ticket(draw_m); perf++; end
      else rand_ticket();
      next_player();
    end
    check("saturated_p0", placar[4:0], 31);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("sat_vencedor", vencedor, (score_m[1] > score_m[0]) ? 1 : 0);

    // Player 1 wins.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    score_m = '{0, 0}; jog_m = 0;
    for (int i = 0; i < 4; i++) t[i] = (draw_m[i] + 1) % 16;
    play_ticket(t);
    next_player();
    play_ticket(draw_m);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("p1_vencedor", vencedor, 1);

    // Reset in the middle of PLAY clears outputs and the draw.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, draw_m[0], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, draw_m[1], 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    check_all_zero("midreset");
    for (int i = 0; i < 3; i++) cyc(1'b1, 7, 1'b0, 1'b0, 1'b0);
    check("idle_ignore_fim", fim, 0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("idle_to_fim", fim, 1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    draw_m = '{0, 0, 0, 0}; score_m = '{0, 0}; jog_m = 0;
    t = '{0, 0, 0, 0}; play_ticket(t);

    repeat (3) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", n_pop, n_push);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loteria_multi.md
Name: loteria_multi

Overview:
- Parametrised successor of the single-game lottery checker.
- Loads a drawn sequence of SEQ_LEN numbers, then scores one ticket per player in turn, for PLAYERS players.
- Each ticket receives a prize code from positional hits and consecutive-hit runs, and the prize points are added to that player's saturating score.
- On game end it reports the winner. The block sits behind the keypad/input sequencer and drives the score display.

Parameters:
- NUM_W, 4, width of each inserted/drawn number.
- SEQ_LEN, 4, numbers per draw and per ticket (>=3).
- PLAYERS, 2, number of players (>=2).
- SCORE_W, 5, per-player score width; scores saturate at 2^SCORE_W-1.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (reset==0 at a rising edge of clock resets the block).
- numero  in  NUM_W  number presented with insere.
- insere  in  1  one number is accepted per cycle while high in LOAD/PLAY.
- carrega  in  1  in IDLE/FIM: start loading a new draw.
- novo_jogo  in  1  in RESULT: next ticket; in FIM: restart scoring with the same draw.
- fim_jogo  in  1  end the game.
- premio  out  2  prize code of the last evaluated ticket.
- premio_valido  out  1  one-cycle pulse when premio/placar update.
- acertos  out  $clog2(SEQ_LEN+1)  hits of the last evaluated ticket.
- jogador  out  $clog2(PLAYERS)  current player index.
- placar  out  PLAYERS*SCORE_W  packed scores; player i occupies [i*SCORE_W +: SCORE_W].
- vencedor  out  $clog2(PLAYERS)  index of the highest score; a tie goes to the lowest index. Valid in FIM.
- fim  out  1  high while in FIM.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, drawn sequence cleared, all indices and counters 0.
  - Reset overrides everything, mid-operation included.
- Input priority when simultaneous: fim_jogo > novo_jogo > carrega > insere. Inputs not listed for a state are ignored.
- IDLE:
  - carrega -> LOAD, load index 0.
  - fim_jogo -> FIM.
  - insere alone is ignored.
- LOAD:
  - Each insere cycle stores numero into draw[idx], idx++.
  - After the SEQ_LEN-th store -> PLAY with jogador=0 and ticket counters cleared.
  - fim_jogo -> IDLE and discards the partial draw.
- PLAY:
  - Each insere cycle compares numero with draw[idx] (positional match).
  - On a match: hit count +1, run +1. Otherwise run=0. maxrun=max(maxrun, run).
  - After the SEQ_LEN-th insere -> EVAL.
  - fim_jogo mid-ticket aborts the ticket: no points, -> FIM.
- EVAL (1 cycle): at the next edge -> RESULT, and on that same edge:
  - premio and acertos are registered.
  - placar[jogador] += points, saturating.
  - premio_valido=1 for exactly that one cycle.
  - Latency: the edge after the last insere edge.
- Prize encoding, first rule that matches:
  - 3 if hits==SEQ_LEN.
  - 2 if maxrun>=3.
  - 1 if hits>=2.
  - 0 otherwise.
- Points per prize code 0/1/2/3: 0/1/2/4. The add is SCORE_W+1 wide, then clamped.
- RESULT:
  - premio and acertos are held.
  - novo_jogo: jogador = (jogador==PLAYERS-1) ? 0 : jogador+1 (wrap-around), clear ticket counters, -> PLAY.
  - fim_jogo -> FIM.
- FIM:
  - fim=1, placar frozen, vencedor registered on entry.
  - novo_jogo: clear placar and jogador, keep the draw, -> PLAY.
  - carrega: clear placar and jogador, -> LOAD.
- premio/acertos keep their last values until the next EVAL or reset.

Decomposition:
- Package loteria_pkg holds:
  - state enum IDLE/LOAD/PLAY/EVAL/RESULT/FIM;
  - prize codes PREMIO_NADA/DOIS/SEQ/TOTAL;
  - points table function;
  - RUN_MIN=3 constant.
- One sub-module, loteria_placar:
  - PLAYERS saturating score registers with add-enable/clear;
  - combinational argmax for vencedor, lowest index on ties.

Test Plan (default parameters, draw 3,5,8,1):
- Hold reset low 2 cycles, then assert insere with carrega=0 -> state stays IDLE; all outputs 0; placar=0.
- carrega, then insere 3,5,8,1; player 0 inserts 3,5,8,1 -> one edge after the last insere: premio=3, acertos=4, premio_valido pulse of 1 cycle, placar[0]=4.
- novo_jogo; player 1 inserts 3,5,8,0 -> premio=2, acertos=3, placar[1]=2. novo_jogo; jogador wraps to 0; inserts 3,0,8,0 -> premio=1, placar[0]=5. Next ticket 0,0,0,0 -> premio=0, scores unchanged.
- Player 0 scores 8 perfect tickets (8 x 4 = 32) -> placar[0] saturates at 31 and does not wrap.
- fim_jogo after 2 inserts in PLAY -> no score change, fim=1, vencedor=0 with scores 5/2. Equal scores 2/2 -> vencedor=0.
- Pull reset low in the middle of PLAY -> next edge: all outputs and the draw are 0, state IDLE. A following insere is ignored until carrega.
